la_frame_capture: RTL and testbench

- Receive end of the logic-analyser time-multiplexed byte bus.
- The transmitter drives one 8-bit slot value per frame for slots 0..7. Each frame lasts FRAME_SIZE+1 clocks. Trigger is high for the whole of slot 0.
- This block locks to the trigger, samples each slot mid-frame and demultiplexes the bytes back into 8 registers. All 8 outputs update together when a full set is captured.
- Sits on the capture/debug side, on the same clock as the transmitter.

---
 rtl/la_frame_capture.sv | 211 +++++++++++++++++++++
 tb/tb_la_frame_capture.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_frame_capture.sv
// la_frame_capture: receive side of the time-multiplexed logic-analyser byte bus.
// Locks to the slot-0 trigger, samples every slot mid-frame and publishes all 8 bytes together.
module la_frame_capture #(
   parameter int FRAME_SIZE   = 15,
   parameter int SAMPLE_POINT = 8,
   parameter int LOCK_FRAMES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       trigger,
   output logic [7:0] reg0,
   output logic [7:0] reg1,
   output logic [7:0] reg2,
   output logic [7:0] reg3,
   output logic [7:0] reg4,
   output logic [7:0] reg5,
   output logic [7:0] reg6,
   output logic [7:0] reg7,
   output logic       frame_valid,
   output logic       locked,
   output logic       sync_err,
   output logic [7:0] err_cnt
);

   localparam int            CW          = (FRAME_SIZE < 1) ? 1 : $clog2(FRAME_SIZE + 1);
   localparam logic [CW-1:0] CYC_ZERO    = CW'(32'd0);
   localparam logic [CW-1:0] CYC_ONE     = CW'(32'd1);
   localparam logic [CW-1:0] CYC_MAX     = CW'(FRAME_SIZE);
   localparam logic [CW-1:0] CYC_SMP     = CW'(SAMPLE_POINT);
   localparam logic [3:0]    GOOD_MAX    = 4'(LOCK_FRAMES);
   localparam logic          SMP_AT_EDGE = (SAMPLE_POINT == 0);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      CAPTURE = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic [7:0]    din_q_r;
   logic          trig_q_r;
   logic          trig_d_r;
   logic [CW-1:0] cyc_r;
   logic [CW-1:0] cyc_s;
   logic [CW-1:0] cyc_inc_s;
   logic [2:0]    slot_r;
   logic [2:0]    slot_s;
   logic [2:0]    slot_inc_s;
   logic [2:0]    stage_idx_s;
   logic [7:0]    staging_r [8];
   logic [3:0]    good_r;
   logic [3:0]    good_inc_s;
   logic          edge_s;
   logic          frame_end_s;
   logic          sample_s;
   logic          stage_we_s;
   logic          commit_s;
   logic          err_s;
   logic          on_time_s;

   // cyc/slot describe the position just reached; *_inc_s is the position the coming edge lands on.
   assign edge_s      = trig_q_r & ~trig_d_r;
   assign cyc_inc_s   = (cyc_r == CYC_MAX) ? CYC_ZERO : cyc_r + CYC_ONE;
   assign slot_inc_s  = (cyc_r == CYC_MAX) ? slot_r + 3'd1 : slot_r;
   assign frame_end_s = (slot_r == 3'd7) && (cyc_r == CYC_MAX);
   assign sample_s    = (cyc_inc_s == CYC_SMP);
   assign good_inc_s  = (good_r == GOOD_MAX) ? good_r : good_r + 4'd1;

   // Next-state, sampling and framing-event decode.
   always_comb begin
      state_s     = state_r;
      cyc_s       = cyc_r;
      slot_s      = slot_r;
      stage_we_s  = 1'b0;
      stage_idx_s = slot_inc_s;
      commit_s    = 1'b0;
      err_s       = 1'b0;
      on_time_s   = 1'b0;
      case (state_r)
         HUNT: begin
            if (edge_s) begin
               state_s     = CAPTURE;
               cyc_s       = CYC_ZERO;
               slot_s      = 3'd0;
               stage_we_s  = SMP_AT_EDGE;
               stage_idx_s = 3'd0;
            end else begin
               state_s = HUNT;
            end
         end
         CAPTURE, COMMIT: begin
            state_s  = CAPTURE;
            cyc_s    = cyc_inc_s;
            slot_s   = slot_inc_s;
            commit_s = (state_r == COMMIT);
            if (edge_s) begin
               cyc_s       = CYC_ZERO;
               slot_s      = 3'd0;
               stage_we_s  = SMP_AT_EDGE;
               stage_idx_s = 3'd0;
               if (frame_end_s) begin
                  on_time_s = 1'b1;
               end else begin
                  err_s    = 1'b1;
                  commit_s = 1'b0;
               end
            end else if (frame_end_s) begin
               err_s    = 1'b1;
               commit_s = 1'b0;
               state_s  = HUNT;
            end else if (sample_s) begin
               // Slot 0 must see the trigger high, every other slot must see it low.
               if (trig_q_r == (slot_inc_s == 3'd0)) begin
                  stage_we_s = 1'b1;
                  if (slot_inc_s == 3'd7) begin
                     state_s = COMMIT;
                  end else begin
                     state_s = CAPTURE;
                  end
               end else begin
                  err_s    = 1'b1;
                  commit_s = 1'b0;
                  state_s  = HUNT;
               end
            end else begin
               state_s = CAPTURE;
            end
         end
         default: begin
            state_s = HUNT;
         end
      endcase
   end

   // Input pipeline, state register and slot/cycle counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         din_q_r  <= 8'h00;
         trig_q_r <= 1'b0;
         trig_d_r <= 1'b0;
         state_r  <= HUNT;
         cyc_r    <= CYC_ZERO;
         slot_r   <= 3'd0;
      end else begin
         din_q_r  <= din;
         trig_q_r <= trigger;
         trig_d_r <= trig_q_r;
         state_r  <= state_s;
         cyc_r    <= cyc_s;
         slot_r   <= slot_s;
      end
   end

   // Staging capture and simultaneous publication of a complete frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            staging_r[i] <= 8'h00;
         end
         reg0        <= 8'h00;
         reg1        <= 8'h00;
         reg2        <= 8'h00;
         reg3        <= 8'h00;
         reg4        <= 8'h00;
         reg5        <= 8'h00;
         reg6        <= 8'h00;
         reg7        <= 8'h00;
         frame_valid <= 1'b0;
      end else begin
         if (stage_we_s) begin
            staging_r[stage_idx_s] <= din_q_r;
         end
         frame_valid <= commit_s;
         if (commit_s) begin
            reg0 <= staging_r[0];
            reg1 <= staging_r[1];
            reg2 <= staging_r[2];
            reg3 <= staging_r[3];
            reg4 <= staging_r[4];
            reg5 <= staging_r[5];
            reg6 <= staging_r[6];
            reg7 <= staging_r[7];
         end
      end
   end

   // Framing-error accounting and lock qualification.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_err <= 1'b0;
         err_cnt  <= 8'h00;
         good_r   <= 4'd0;
         locked   <= 1'b0;
      end else begin
         sync_err <= err_s;
         if (err_s) begin
            good_r <= 4'd0;
            locked <= 1'b0;
            if (err_cnt != 8'hFF) begin
               err_cnt <= err_cnt + 8'd1;
            end
         end else if (on_time_s) begin
            good_r <= good_inc_s;
            locked <= (good_inc_s == GOOD_MAX);
         end
      end
   end

endmodule

// File: tb/tb_la_frame_capture.sv
// Bench for la_frame_capture: a frame-level transmitter model with random slot bytes drives the bus,
// and expected event times/values come from the frame start edge and the bytes that were sent.
module tb_la_frame_capture;

   localparam int FS = 15;
   localparam int FL = FS + 1;
   localparam int SP = 8;
   localparam int LF = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       trigger;
   logic [7:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
   logic       frame_valid;
   logic       locked;
   logic       sync_err;
   logic [7:0] err_cnt;

   la_frame_capture #(
      .FRAME_SIZE   (FS),
      .SAMPLE_POINT (SP),
      .LOCK_FRAMES  (LF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .trigger     (trigger),
      .reg0        (reg0),
      .reg1        (reg1),
      .reg2        (reg2),
      .reg3        (reg3),
      .reg4        (reg4),
      .reg5        (reg5),
      .reg6        (reg6),
      .reg7        (reg7),
      .frame_valid (frame_valid),
      .locked      (locked),
      .sync_err    (sync_err),
      .err_cnt     (err_cnt)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         failures = 0;
   int         n = 0;
   int         fv_seen = 0;
   int         err_seen = 0;
   int         start_edge = 0;
   int         errs_model = 0;
   int         e;
   logic       tx_run, tx_stuck, tx_stop, idle_trig;
   int         tx_pos;
   logic [7:0] tx_vals [8];
   logic [63:0] exp_hold;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] packed_vals();
      return {tx_vals[0], tx_vals[1], tx_vals[2], tx_vals[3],
              tx_vals[4], tx_vals[5], tx_vals[6], tx_vals[7]};
   endfunction

   function automatic logic [63:0] regs_now();
      return {reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7};
   endfunction

   function automatic logic [63:0] sat_errs();
      return 64'((errs_model > 255) ? 255 : errs_model);
   endfunction

   task automatic new_vals();
      for (int i = 0; i < 8; i++) begin
         tx_vals[i] = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic tx_start(input logic stuck);
      tx_run   = 1'b1;
      tx_pos   = 0;
      tx_stuck = stuck;
      tx_stop  = 1'b0;
      new_vals();
   endtask

   // One clock: drive the transmitter position, wait for the edge, observe outputs #1 later.
   task automatic tick();
      logic       t;
      logic [7:0] d;
      if (tx_run) begin
         t = (tx_pos < FL) || (tx_stuck && (tx_pos < 2 * FL));
         d = tx_vals[tx_pos / FL];
         if (tx_pos == 0) start_edge = n + 1;
      end else begin
         t = idle_trig;
         d = 8'($urandom_range(0, 255));
      end
      trigger = t;
      din     = d;
      @(posedge clk);
      #1;
      n++;
      if (frame_valid === 1'b1) fv_seen++;
      if (sync_err === 1'b1) err_seen++;
      if (tx_run) begin
         if (tx_pos == 8 * FL - 1) begin
            tx_pos = 0;
            if (tx_stop) tx_run = 1'b0;
            else new_vals();
         end else begin
            tx_pos++;
         end
      end
   endtask

   task automatic run_to(input int target);
      while (n < target) tick();
   endtask

   initial begin
      rst = 1'b1; trigger = 1'b0; din = 8'h00; idle_trig = 1'b0;
      tx_run = 1'b0; tx_stuck = 1'b0; tx_stop = 1'b0; tx_pos = 0;
      for (int i = 0; i < 8; i++) tx_vals[i] = 8'h00;

      // Reset with the trigger toggling.
      for (int i = 0; i < 3; i++) begin
         idle_trig = ~idle_trig;
         tick();
         chk("rst_regs", regs_now(), 64'd0);
         chk("rst_fv", 64'(frame_valid), 64'd0);
         chk("rst_locked", 64'(locked), 64'd0);
         chk("rst_sync_err", 64'(sync_err), 64'd0);
         chk("rst_err_cnt", 64'(err_cnt), 64'd0);
      end
      rst = 1'b0; idle_trig = 1'b0;
      repeat (3) tick();
      chk("idle_fv_cnt", 64'(fv_seen), 64'd0);

      // Nominal stream, first frame 0x11..0x88, then random frames.
      fv_seen = 0; err_seen = 0;
      tx_start(1'b0);
      tx_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      tick();
      e = start_edge + 1;
      run_to(e + 120);
      chk("nom_pre_fv_cnt", 64'(fv_seen), 64'd0);
      chk("nom_pre_regs", regs_now(), 64'd0);
      tick();
      chk("nom_fv1", 64'(frame_valid), 64'd1);
      chk("nom_regs1", regs_now(), packed_vals());
      chk("nom_regs1_const", regs_now(), 64'h1122334455667788);
      tick();
      chk("nom_fv1_pulse", 64'(frame_valid), 64'd0);
      run_to(e + 248);
      chk("nom_fv_cnt_mid", 64'(fv_seen), 64'd1);
      tick();
      chk("nom_fv2", 64'(frame_valid), 64'd1);
      chk("nom_regs2", regs_now(), packed_vals());
      run_to(e + 255);
      chk("nom_not_locked", 64'(locked), 64'd0);
      tick();
      chk("nom_locked", 64'(locked), 64'd1);
      chk("nom_err_seen", 64'(err_seen), 64'd0);
      chk("nom_err_cnt", 64'(err_cnt), 64'd0);

      // Early edge: transmitter restarts a frame at slot 3 of a locked stream.
      run_to(start_edge + 47);
      tx_pos = 0;
      new_vals();
      tick();
      e = start_edge + 1;
      chk("early_pre_locked", 64'(locked), 64'd1);
      chk("early_pre_err", 64'(sync_err), 64'd0);
      fv_seen = 0; err_seen = 0;
      tick();
      errs_model = 1;
      chk("early_sync_err", 64'(sync_err), 64'd1);
      chk("early_unlocked", 64'(locked), 64'd0);
      chk("early_err_cnt", 64'(err_cnt), sat_errs());
      tick();
      chk("early_err_pulse", 64'(sync_err), 64'd0);
      run_to(e + 120);
      chk("early_no_old_fv", 64'(fv_seen), 64'd0);
      tick();
      chk("early_fv", 64'(frame_valid), 64'd1);
      chk("early_regs", regs_now(), packed_vals());
      chk("early_err_seen", 64'(err_seen), 64'd1);

      // Missing edge: trigger held low after the committed frame.
      tx_stop = 1'b1;
      exp_hold = packed_vals();
      run_to(e + 127);
      chk("miss_pre_err", 64'(sync_err), 64'd0);
      tick();
      errs_model++;
      chk("miss_sync_err", 64'(sync_err), 64'd1);
      chk("miss_unlocked", 64'(locked), 64'd0);
      chk("miss_err_cnt", 64'(err_cnt), sat_errs());
      fv_seen = 0; err_seen = 0;
      run_to(n + 300);
      chk("miss_no_fv", 64'(fv_seen), 64'd0);
      chk("miss_no_err", 64'(err_seen), 64'd0);
      chk("miss_regs_hold", regs_now(), exp_hold);
      chk("miss_err_cnt_hold", 64'(err_cnt), sat_errs());

      // Level error: trigger stuck high into slot 1, repeated past saturation.
      fv_seen = 0;
      for (int i = 0; i < 300; i++) begin
         tx_start(1'b1);
         tick();
         e = start_edge + 1;
         run_to(e + 23);
         chk("lvl_pre_err", 64'(sync_err), 64'd0);
         tick();
         errs_model++;
         chk("lvl_sync_err", 64'(sync_err), 64'd1);
         chk("lvl_err_cnt", 64'(err_cnt), sat_errs());
         tx_run = 1'b0;
         repeat (6) tick();
      end
      chk("lvl_no_fv", 64'(fv_seen), 64'd0);
      chk("lvl_unlocked", 64'(locked), 64'd0);
      chk("lvl_err_sat", 64'(err_cnt), 64'd255);
      repeat (20) tick();
      chk("lvl_err_sat_hold", 64'(err_cnt), 64'd255);
      tx_stuck = 1'b0;

      // Reset in slot 4 of a good frame, then a clean capture on the next edge.
      tx_start(1'b0);
      tick();
      e = start_edge + 1;
      run_to(e + 4 * FL + 5);
      rst = 1'b1;
      tick();
      tick();
      chk("mrst_regs", regs_now(), 64'd0);
      chk("mrst_fv", 64'(frame_valid), 64'd0);
      chk("mrst_locked", 64'(locked), 64'd0);
      chk("mrst_err_cnt", 64'(err_cnt), 64'd0);
      rst = 1'b0;
      fv_seen = 0; err_seen = 0;
      e = e + 8 * FL;
      run_to(e + 120);
      chk("mrst_no_fv", 64'(fv_seen), 64'd0);
      tick();
      chk("mrst_fv", 64'(frame_valid), 64'd1);
      chk("mrst_regs_new", regs_now(), packed_vals());
      chk("mrst_err_seen", 64'(err_seen), 64'd0);
      chk("mrst_err_cnt_after", 64'(err_cnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
